// File: rtl/sysbus_responder.sv
// Memory-side responder for the 64-bit tagged system bus: burst reads, burst writes, one completion beat per write.
// Optional SYSBUS_RESP_DELAY_EN inserts RESP_DELAY idle cycles before the first response beat.
module sysbus_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int BURST_LEN      = 8,
    parameter int RESP_DELAY     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [AW-1:0] BASE_MASK = ~AW'(BURST_LEN - 1);

    if (RESP_DELAY < 1) begin : g_bad_delay
        $error("RESP_DELAY must be at least 1");
    end
    if ((MEM_WORDS & (MEM_WORDS - 1)) != 0 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_pow2
        $error("MEM_WORDS and BURST_LEN must be powers of two");
    end

    typedef enum logic [1:0] {IDLE, WDATA, DELAY, RESP} state_t;

`ifdef SYSBUS_RESP_DELAY_EN
    localparam state_t POST_STATE = DELAY;
    localparam int DCW = $clog2(RESP_DELAY + 1);
    logic [DCW-1:0] dly_q;
`else
    localparam state_t POST_STATE = RESP;
`endif

    state_t                    state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [BUS_DATA_WIDTH-1:0] addr_q;
    logic [BUS_TAG_WIDTH-1:0]  tag_q;
    logic [AW-1:0]             base_q;
    logic [BW-1:0]             beat_q, beat_nxt;
    logic [AW-1:0]             rd_idx, rd_idx_nxt;
    logic                      is_wr;
    logic addr_beat, wdata_beat, last_wbeat, beat_ack, resp_done, read_load, dly_done, wr_resp_start;

    assign is_wr      = tag_q[BUS_TAG_WIDTH-1];
    assign beat_nxt   = beat_q + BW'(1);
    assign rd_idx     = base_q + AW'(beat_q);
    assign rd_idx_nxt = base_q + AW'(beat_nxt);

    always_comb begin
        state_d       = state_q;
        addr_beat     = (state_q == IDLE) && bus_reqcyc;
        // The initiator still holds the address during the ack cycle, so that cycle is not data.
        wdata_beat    = (state_q == WDATA) && bus_reqcyc && !bus_reqack;
        last_wbeat    = wdata_beat && (beat_q == LAST_BEAT);
        beat_ack      = (state_q == RESP) && bus_respcyc && bus_respack;
        resp_done     = beat_ack && (is_wr || (beat_q == LAST_BEAT));
        read_load     = (state_q == RESP) && !bus_respcyc && !is_wr;
`ifdef SYSBUS_RESP_DELAY_EN
        dly_done      = (state_q == DELAY) && (dly_q == DCW'(RESP_DELAY - 1));
        wr_resp_start = dly_done && is_wr;
`else
        dly_done      = 1'b0;
        wr_resp_start = last_wbeat;
`endif
        case (state_q)
            IDLE:  if (bus_reqcyc) state_d = bus_reqtag[BUS_TAG_WIDTH-1] ? WDATA : POST_STATE;
            WDATA: if (last_wbeat) state_d = POST_STATE;
            DELAY: if (dly_done) state_d = RESP;
            RESP:  if (resp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Backing store is never reset; beats written before an abort stay written.
    always_ff @(posedge clk) begin
        if (wdata_beat) mem[rd_idx] <= bus_req;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
            addr_q      <= '0;
            tag_q       <= '0;
            base_q      <= '0;
            beat_q      <= '0;
        end else begin
            bus_reqack <= addr_beat;
            if (addr_beat) begin
                addr_q <= bus_req;
                tag_q  <= bus_reqtag;
                base_q <= bus_req[AW+2:3] & BASE_MASK;
                beat_q <= '0;
            end
            // Wraps to zero after the last write beat, ready for nothing else to reuse.
            if (wdata_beat) beat_q <= beat_nxt;
            if (wr_resp_start) begin
                bus_respcyc <= 1'b1;
                bus_resp    <= addr_q;
                bus_resptag <= tag_q;
            end else if (read_load) begin
                bus_respcyc <= 1'b1;
                bus_resp    <= mem[rd_idx];
                bus_resptag <= tag_q;
            end else if (beat_ack) begin
                if (resp_done) begin
                    bus_respcyc <= 1'b0;
                    beat_q      <= '0;
                end else begin
                    beat_q   <= beat_nxt;
                    bus_resp <= mem[rd_idx_nxt];
                end
            end
        end
    end

`ifdef SYSBUS_RESP_DELAY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 dly_q <= '0;
        else if (state_q == DELAY)  dly_q <= dly_done ? '0 : dly_q + DCW'(1);
    end
`endif

endmodule
